wb_sdrc_burst_master: RTL and testbench
=======================================

Name: wb_sdrc_burst_master

Overview:
Wishbone initiator for the SDRAM controller's Wishbone slave port. It accepts a simple command (read or write, start address, beat count) and streams write data in or read data out. It executes each command as one Wishbone classic or incrementing-burst cycle and signals completion. It sits between on-chip traffic sources (DMA, test engines) and the SDRAM controller, on sys_clk.

Parameters:
APP_AW, 26, Wishbone address width (byte address)
dw, 32, Wishbone data width
LEN_W, 8, width of beat-count field; command length = cmd_len+1 beats
TIMEOUT, 1023, ack watchdog limit in cycles (used only with WB_TIMEOUT_EN)

Ports:
sys_clk  in  1  clock; all logic on rising edge
wb_rst_i  in  1  synchronous active-high reset
sdr_init_done  in  1  controller init complete; no command accepted while low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_we  in  1  1=write, 0=read
cmd_addr  in  APP_AW  start byte address (dw/8-aligned)
cmd_len  in  LEN_W  beats minus one
wr_data  in  dw  write beat data
wr_valid  in  1  write beat available
wr_ready  out  1  write beat consumed
rd_data  out  dw  read beat data
rd_valid  out  1  read beat strobe, one cycle per beat
done  out  1  one-cycle pulse at command end
err  out  1  one-cycle pulse with done on timeout abort
wb_cyc_i  out  1  Wishbone cycle
wb_stb_i  out  1  Wishbone strobe
wb_we_i  out  1  Wishbone write enable
wb_cti_i  out  3  cycle type
wb_sel_i  out  dw/8  byte selects, all ones during a cycle
wb_addr_i  out  APP_AW  Wishbone address
wb_dat_i  out  dw  Wishbone write data
wb_ack_o  in  1  slave acknowledge
wb_dat_o  in  dw  slave read data

Behaviour:
- Reset (wb_rst_i high at clock edge): state IDLE. wb_cyc_i, wb_stb_i, wb_we_i, rd_valid, done, err, cmd_ready = 0. wb_cti_i = 3'b000. wb_sel_i, wb_addr_i, wb_dat_i, rd_data = 0. Beat counter and watchdog = 0. Reset mid-cycle aborts the cycle; no done is issued.
- FSM states: IDLE, RUN, FIN.
- IDLE: cmd_ready = sdr_init_done. On accept, latch cmd_we, cmd_addr, cmd_len. Next cycle: RUN, wb_cyc_i=1, wb_we_i=cmd_we, wb_addr_i=cmd_addr, beat counter = cmd_len.
- RUN, read: wb_stb_i held 1. On each wb_ack_o: wb_addr_i += dw/8; counter decrements; rd_data<=wb_dat_o and rd_valid=1 on the next cycle (1-cycle latency). No backpressure on read data.
- RUN, write: wb_stb_i = wr_valid (combinational). wb_dat_i = wr_data. wr_ready = wb_ack_o. When wr_valid is low, stb drops and cyc stays high (wait states).
- wb_cti_i: 3'b000 when cmd_len==0. Otherwise 3'b010 on every beat except the last, which is 3'b111.
- On ack of the last beat (counter==0): wb_cyc_i, wb_stb_i drop next cycle; state FIN.
- FIN: done=1 for one cycle (coincides with rd_valid of the final read beat); return to IDLE. cmd_ready is 0 in RUN and FIN, so there is no back-to-back acceptance within a cycle.
- Address arithmetic is modulo 2^APP_AW: wrap from all-ones to 0 is silent.
- cmd_len = 2^LEN_W-1 gives the maximum of 256 beats (default).
- sdr_init_done falling during RUN is ignored; the current cycle completes.
- wb_ack_o outside RUN is ignored.

Optional Feature:
WB_TIMEOUT_EN
- Defined: a watchdog counts cycles in RUN with stb high and no ack, and clears on each ack. When it reaches TIMEOUT, wb_cyc_i and wb_stb_i drop next cycle, the remaining beats are discarded (no rd_valid), and the block goes to FIN with done=1 and err=1.
- Undefined: no watchdog, err tied 0, and the block waits for ack indefinitely.

Test Plan:
- sdr_init_done=0, cmd_valid=1 -> cmd_ready=0 and no wb_cyc_i. Raise init_done -> accepted next cycle.
- Write cmd_addr=0x100, cmd_len=0, wr_data=0xDEADBEEF, ack after 3 cycles -> one beat, wb_cti_i=000, wb_addr_i=0x100, wr_ready pulses once, done 1 cycle after ack.
- Read cmd_addr=0x3FFFFF8, cmd_len=3, ack every cycle -> wb_addr_i sequence 0x3FFFFF8, 0x3FFFFFC, 0x0000000, 0x0000004. wb_cti_i 010,010,010,111. Four rd_valid pulses with wb_dat_o values delayed 1 cycle. done with the last rd_valid.
- Write of 4 beats with wr_valid low for 2 cycles after beat 1 -> wb_stb_i low for those cycles, wb_cyc_i stays high, all 4 beats written in order.
- wb_rst_i asserted during beat 2 of an 8-beat read -> next cycle wb_cyc_i=0, wb_stb_i=0, no done. A new command is accepted after reset.
- With WB_TIMEOUT_EN and TIMEOUT=16, no ack -> cyc drops after 16 stalled cycles, done=err=1 same cycle. Without the macro -> cyc stays high.

Source files
------------

// File: rtl/wb_sdrc_burst_master.sv
// rtl/wb_sdrc_burst_master.sv - Wishbone burst initiator for the SDRAM controller slave port (optional watchdog: WB_TIMEOUT_EN)
module wb_sdrc_burst_master #(
    parameter int APP_AW  = 26,
    parameter int dw      = 32,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic              sys_clk,
    input  logic              wb_rst_i,
    input  logic              sdr_init_done,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [dw-1:0]     wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [dw-1:0]     rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              err,
    output logic              wb_cyc_i,
    output logic              wb_stb_i,
    output logic              wb_we_i,
    output logic [2:0]        wb_cti_i,
    output logic [dw/8-1:0]   wb_sel_i,
    output logic [APP_AW-1:0] wb_addr_i,
    output logic [dw-1:0]     wb_dat_i,
    input  logic              wb_ack_o,
    input  logic [dw-1:0]     wb_dat_o
);

    localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(dw / 8);
    localparam int                WD_W      = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t              state_q, state_d;
    logic                we_q;
    logic                len_zero_q;
    logic                err_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [APP_AW-1:0]   addr_q;
    logic [dw-1:0]       rd_data_q;
    logic                rd_valid_q;

    logic                run;
    logic                accept;
    logic                stb;
    logic                beat_ack;
    logic                last_beat;
    logic                timeout_hit;

    assign run       = (state_q == RUN);
    assign accept    = (state_q == IDLE) && sdr_init_done && cmd_valid && !wb_rst_i;
    // Reads strobe continuously; writes only strobe while the source has a beat ready.
    assign stb       = run && (we_q ? wr_valid : 1'b1);
    assign beat_ack  = stb && wb_ack_o;
    assign last_beat = (cnt_q == '0);

`ifdef WB_TIMEOUT_EN
    logic [WD_W-1:0] wdog_q;

    // Watchdog: counts strobed cycles without ack, cleared by every ack and outside RUN.
    always_ff @(posedge sys_clk) begin
        if (wb_rst_i) begin
            wdog_q <= '0;
        end else if (!run || beat_ack) begin
            wdog_q <= '0;
        end else if (stb) begin
            wdog_q <= wdog_q + 1'b1;
        end
    end

    assign timeout_hit = stb && !wb_ack_o && (wdog_q == WD_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (WD_W == 0);
    assign timeout_hit    = 1'b0;
`endif

    // State register.
    always_ff @(posedge sys_clk) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and bus-facing outputs decoded from the current state.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        wb_cti_i  = 3'b000;
        wb_sel_i  = '0;
        wb_dat_i  = '0;
        wr_ready  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = sdr_init_done && !wb_rst_i;
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wb_cyc_i = 1'b1;
                wb_stb_i = stb;
                wb_we_i  = we_q;
                wb_sel_i = '1;
                if (!len_zero_q) begin
                    wb_cti_i = last_beat ? 3'b111 : 3'b010;
                end
                if (we_q) begin
                    wb_dat_i = wr_data;
                    wr_ready = beat_ack;
                end
                if (timeout_hit || (beat_ack && last_beat)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Command latch, address/beat bookkeeping and one-cycle-delayed read data.
    always_ff @(posedge sys_clk) begin
        if (wb_rst_i) begin
            we_q       <= 1'b0;
            len_zero_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (accept) begin
                we_q       <= cmd_we;
                addr_q     <= cmd_addr;
                cnt_q      <= cmd_len;
                len_zero_q <= (cmd_len == '0);
                err_q      <= 1'b0;
            end
            if (beat_ack) begin
                addr_q <= addr_q + ADDR_STEP;
                cnt_q  <= cnt_q - 1'b1;
                if (!we_q) begin
                    rd_data_q  <= wb_dat_o;
                    rd_valid_q <= 1'b1;
                end
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign wb_addr_i = addr_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_wb_sdrc_burst_master.sv
// tb/tb_wb_sdrc_burst_master.sv - directed self-checking bench for wb_sdrc_burst_master
module tb_wb_sdrc_burst_master;

    localparam int APP_AW = 26;
    localparam int DW     = 32;
    localparam int LEN_W  = 8;

    logic              sys_clk = 1'b0;
    logic              wb_rst_i;
    logic              sdr_init_done;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [APP_AW-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic [DW-1:0]     wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              done;
    logic              err;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [2:0]        wb_cti_i;
    logic [DW/8-1:0]   wb_sel_i;
    logic [APP_AW-1:0] wb_addr_i;
    logic [DW-1:0]     wb_dat_i;
    logic              wb_ack_o;
    logic [DW-1:0]     wb_dat_o;

    int n_cmp = 0;
    int n_bad = 0;

    wb_sdrc_burst_master #(
        .APP_AW  (APP_AW),
        .dw      (DW),
        .LEN_W   (LEN_W),
        .TIMEOUT (16)
    ) dut (
        .sys_clk       (sys_clk),
        .wb_rst_i      (wb_rst_i),
        .sdr_init_done (sdr_init_done),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_we        (cmd_we),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .done          (done),
        .err           (err),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_we_i       (wb_we_i),
        .wb_cti_i      (wb_cti_i),
        .wb_sel_i      (wb_sel_i),
        .wb_addr_i     (wb_addr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_ack_o      (wb_ack_o),
        .wb_dat_o      (wb_dat_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [APP_AW-1:0] addr, input logic [LEN_W-1:0] len);
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_valid = 1'b1;
        #1;
        check("issue_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        #1;
    endtask

    initial begin
        logic [APP_AW-1:0] rd_addr_exp [4];
        logic [2:0]        cti_exp     [4];
        logic [DW-1:0]     wdat        [4];

        rd_addr_exp = '{26'h3FFFFF8, 26'h3FFFFFC, 26'h0000000, 26'h0000004};
        cti_exp     = '{3'b010, 3'b010, 3'b010, 3'b111};
        wdat        = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

        wb_rst_i = 1'b1; sdr_init_done = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_addr = '0; cmd_len = '0; wr_data = '0; wr_valid = 1'b0;
        wb_ack_o = 1'b0; wb_dat_o = '0;

        // Reset state
        step(); step();
        check("rst_cyc", wb_cyc_i, 1'b0);
        check("rst_stb", wb_stb_i, 1'b0);
        check("rst_cti", wb_cti_i, 3'b000);
        check("rst_sel", wb_sel_i, 4'h0);
        check("rst_addr", wb_addr_i, 26'h0);
        check("rst_rdv", rd_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        wb_rst_i = 1'b0;

        // Held off until init completes, then single-beat write
        cmd_we = 1'b1; cmd_addr = 26'h100; cmd_len = 8'd0; cmd_valid = 1'b1;
        step();
        check("noinit_ready", cmd_ready, 1'b0);
        step();
        check("noinit_cyc", wb_cyc_i, 1'b0);
        sdr_init_done = 1'b1;
        #1;
        check("init_ready", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        wr_data = 32'hDEADBEEF; wr_valid = 1'b1;
        #1;
        check("w1_cyc", wb_cyc_i, 1'b1);
        check("w1_we", wb_we_i, 1'b1);
        check("w1_addr", wb_addr_i, 26'h100);
        check("w1_cti", wb_cti_i, 3'b000);
        check("w1_sel", wb_sel_i, 4'hF);
        check("w1_dat", wb_dat_i, 32'hDEADBEEF);
        check("w1_busy_ready", cmd_ready, 1'b0);
        check("w1_wr_ready0", wr_ready, 1'b0);
        step();
        check("w1_wait_stb", wb_stb_i, 1'b1);
        step();
        wb_ack_o = 1'b1;
        #1;
        check("w1_wr_ready", wr_ready, 1'b1);
        step();
        wb_ack_o = 1'b0; wr_valid = 1'b0;
        #1;
        check("w1_done", done, 1'b1);
        check("w1_err", err, 1'b0);
        check("w1_cyc_off", wb_cyc_i, 1'b0);
        check("w1_wr_ready_off", wr_ready, 1'b0);
        step();
        check("w1_done_off", done, 1'b0);

        // Four-beat read wrapping the top of the address space
        issue(1'b0, 26'h3FFFFF8, 8'd3);
        for (int i = 0; i < 4; i++) begin
            wb_ack_o = 1'b1;
            wb_dat_o = 32'hA000_0000 + 32'(i);
            #1;
            check("r4_addr", wb_addr_i, rd_addr_exp[i]);
            check("r4_cti", wb_cti_i, cti_exp[i]);
            check("r4_stb", wb_stb_i, 1'b1);
            check("r4_rdv", rd_valid, i > 0);
            if (i > 0) check("r4_rdat", rd_data, 32'hA000_0000 + 32'(i - 1));
            check("r4_done_early", done, 1'b0);
            step();
        end
        wb_ack_o = 1'b0;
        #1;
        check("r4_last_rdv", rd_valid, 1'b1);
        check("r4_last_rdat", rd_data, 32'hA000_0003);
        check("r4_done", done, 1'b1);
        check("r4_cyc_off", wb_cyc_i, 1'b0);
        step();
        check("r4_rdv_off", rd_valid, 1'b0);

        // Four-beat write with a two-cycle source gap after the second beat
        issue(1'b1, 26'h200, 8'd3);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                wr_valid = 1'b0; wb_ack_o = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    #1;
                    check("w4_gap_stb", wb_stb_i, 1'b0);
                    check("w4_gap_cyc", wb_cyc_i, 1'b1);
                    step();
                end
            end
            wr_valid = 1'b1; wr_data = wdat[i]; wb_ack_o = 1'b1;
            #1;
            check("w4_addr", wb_addr_i, 26'h200 + 26'(4 * i));
            check("w4_dat", wb_dat_i, wdat[i]);
            check("w4_cti", wb_cti_i, cti_exp[i]);
            check("w4_wr_ready", wr_ready, 1'b1);
            step();
        end
        wr_valid = 1'b0; wb_ack_o = 1'b0;
        #1;
        check("w4_done", done, 1'b1);
        step();

        // Reset during beat 2 of an eight-beat read
        issue(1'b0, 26'h40, 8'd7);
        wb_ack_o = 1'b1; wb_dat_o = 32'h5;
        step();
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0; wb_ack_o = 1'b0;
        #1;
        check("rstmid_cyc", wb_cyc_i, 1'b0);
        check("rstmid_stb", wb_stb_i, 1'b0);
        check("rstmid_done", done, 1'b0);
        step();
        check("rstmid_done2", done, 1'b0);
        issue(1'b0, 26'h80, 8'd0);
        wb_ack_o = 1'b1; wb_dat_o = 32'hCAFE_F00D;
        #1;
        check("post_addr", wb_addr_i, 26'h80);
        check("post_cti", wb_cti_i, 3'b000);
        step();
        wb_ack_o = 1'b0;
        #1;
        check("post_done", done, 1'b1);
        check("post_rdat", rd_data, 32'hCAFE_F00D);
        step();

        // Stalled slave: watchdog aborts after 16 cycles when enabled
        issue(1'b0, 26'h10, 8'd1);
        for (int c = 0; c < 16; c++) begin
            check("to_cyc_hold", wb_cyc_i, 1'b1);
            step();
        end
`ifdef WB_TIMEOUT_EN
        check("to_cyc_drop", wb_cyc_i, 1'b0);
        check("to_done", done, 1'b1);
        check("to_err", err, 1'b1);
        check("to_rdv", rd_valid, 1'b0);
        step();
        check("to_err_off", err, 1'b0);
`else
        check("nto_cyc", wb_cyc_i, 1'b1);
        check("nto_done", done, 1'b0);
        check("nto_err", err, 1'b0);
        wb_ack_o = 1'b1;
        step(); step();
        wb_ack_o = 1'b0;
        #1;
        check("nto_fin_done", done, 1'b1);
        check("nto_fin_err", err, 1'b0);
        step();
`endif
        check("end_idle_ready", cmd_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
